// File: rtl/vending_pkg.sv
// Shared encodings for the vending machine family: FSM states, coin codes and coin values.
package vending_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned COIN_W  = 2;
  localparam int unsigned VALUE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'b000,
    VEND   = 3'b100,
    CHANGE = 3'b101,
    REFUND = 3'b110
  } state_t;

  localparam logic [COIN_W-1:0] COIN_NONE = 2'b00;
  localparam logic [COIN_W-1:0] COIN_5    = 2'b01;
  localparam logic [COIN_W-1:0] COIN_10   = 2'b10;
  localparam logic [COIN_W-1:0] COIN_INV  = 2'b11;

  localparam logic [VALUE_W-1:0] VALUE_5  = 4'd5;
  localparam logic [VALUE_W-1:0] VALUE_10 = 4'd10;

endpackage

// File: rtl/vm_coin_decode.sv
// Combinational coin-code decoder: flags a valid coin and reports its rupee value.
module vm_coin_decode
  import vending_pkg::*;
(
  input  logic [COIN_W-1:0]  coin,
  output logic               valid,
  output logic [VALUE_W-1:0] value
);

  // Map the acceptor code onto {valid, value}; none and invalid both decode to zero value.
  always_comb begin
    valid = 1'b0;
    value = '0;
    case (coin)
      COIN_5: begin
        valid = 1'b1;
        value = VALUE_5;
      end
      COIN_10: begin
        valid = 1'b1;
        value = VALUE_10;
      end
      default: begin
        valid = 1'b0;
        value = '0;
      end
    endcase
  end

endmodule

// File: rtl/vending_machine_param.sv
// Parametrised coin vending machine: credit counter, stock counter, change/refund as 5-unit pulse trains.
module vending_machine_param
  import vending_pkg::*;
#(
  parameter int unsigned PRICE     = 15,
  parameter int unsigned CREDIT_W  = 6,
  parameter int unsigned STOCK_MAX = 8,
  parameter int unsigned STOCK_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [COIN_W-1:0]   coin,
  input  logic                cancel,
  input  logic                refill,
  output logic                dispense,
  output logic                return5,
  output logic                reject,
  output logic                sold_out,
  output logic [CREDIT_W-1:0] credit,
  output logic [STOCK_W-1:0]  stock,
  output logic [STATE_W-1:0]  current_state
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] FIVE_C  = CREDIT_W'(5);
  localparam logic [STOCK_W-1:0]  FULL_C  = STOCK_W'(STOCK_MAX);
  localparam logic [STOCK_W-1:0]  ONE_S   = STOCK_W'(1);

  state_t               state;
  state_t               state_next;
  logic                 coin_valid;
  logic [VALUE_W-1:0]   coin_value;
  logic [CREDIT_W-1:0]  credit_sum;
  logic [CREDIT_W-1:0]  vend_left;
  logic [CREDIT_W-1:0]  change_left;
  logic                 cancel_go;
  logic                 accept;

  vm_coin_decode u_decode (
    .coin  (coin),
    .valid (coin_valid),
    .value (coin_value)
  );

  // Shared arithmetic and the accept/cancel qualifiers; cancel with credit outranks a same-cycle coin.
  always_comb begin
    credit_sum  = credit + CREDIT_W'(coin_value);
    vend_left   = credit - PRICE_C;
    change_left = credit - FIVE_C;
    cancel_go   = cancel && (credit != '0);
    accept      = (state == IDLE) && coin_valid && (stock != '0) && !cancel_go;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; change and refund drain until the 5-unit step empties the credit.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cancel_go) begin
          state_next = REFUND;
        end else if (accept && (credit_sum >= PRICE_C)) begin
          state_next = VEND;
        end
      end
      VEND: begin
        state_next = (vend_left != '0) ? CHANGE : IDLE;
      end
      CHANGE, REFUND: begin
        if (credit <= FIVE_C) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore output decode from the registered state and stock.
  always_comb begin
    dispense      = (state == VEND);
    return5       = (state == CHANGE) || (state == REFUND);
    sold_out      = (stock == '0);
    current_state = state;
  end

  // Credit and stock counters plus the registered reject pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit <= '0;
      stock  <= FULL_C;
      reject <= 1'b0;
    end else begin
      reject <= (coin == COIN_INV) || (coin_valid && !accept);
      case (state)
        IDLE: begin
          if (refill) begin
            stock <= FULL_C;
          end
          if (accept) begin
            credit <= credit_sum;
          end
        end
        VEND: begin
          stock  <= stock - ONE_S;
          credit <= vend_left;
        end
        CHANGE, REFUND: begin
          credit <= (credit > FIVE_C) ? change_left : '0;
        end
        default: begin
          credit <= credit;
        end
      endcase
    end
  end

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
Parametrised successor to the single-price coin vending FSM. It accumulates credit in a counter rather than in per-value states, and vends at a configurable PRICE. Change of any size is returned as a train of 5-unit pulses. It adds cancel/refund, invalid-coin reject, and a stock counter with sold-out and refill. It sits between the coin acceptor front end and the dispense/return actuators.

Parameters:
PRICE, 15, item price in rupees; must be a nonzero multiple of 5 and at most 2^CREDIT_W-1-10
CREDIT_W, 6, width of the credit register
STOCK_MAX, 8, item count loaded at reset and on refill; must be at least 1
STOCK_W, 4, width of the stock counter; 2^STOCK_W-1 must be at least STOCK_MAX

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
coin  in  2  00 = none, 01 = Rs5, 10 = Rs10, 11 = invalid; valid for one cycle per coin
cancel  in  1  request refund of the accumulated credit
refill  in  1  reload stock to STOCK_MAX
dispense  out  1  high for exactly one cycle per vend
return5  out  1  one cycle high per Rs5 returned
reject  out  1  one-cycle pulse: the coin sampled on the previous edge was refused
sold_out  out  1  high while stock == 0
credit  out  CREDIT_W  current credit register value
stock  out  STOCK_W  items remaining
current_state  out  3  encoded FSM state

Behaviour:
- Reset: one clock, asynchronous active-high reset.
  - On reset: state=IDLE, credit=0, stock=STOCK_MAX, dispense=0, return5=0, reject=0, sold_out=0.
  - Reset mid-operation discards credit and any pending change; no further return5 pulses.
- States and encodings: IDLE 000, VEND 100, CHANGE 101, REFUND 110. Other codes go to IDLE.
- Outputs are Moore-decoded from registered state:
  - dispense = (state==VEND).
  - return5 = (state==CHANGE or state==REFUND).
  - reject is a registered pulse, asserted the cycle after the offending coin is sampled.
- IDLE, coin sampled at edge N:
  - Valid coin with stock>0: credit <= credit+value at edge N.
  - If credit+value >= PRICE: state <= VEND at edge N, so dispense is high in cycle N+1.
  - Otherwise remain in IDLE.
- IDLE cancel, credit>0: state <= REFUND, and any coin sampled in that same cycle is rejected (cancel wins). Cancel with credit==0 is ignored.
- IDLE refill: stock <= STOCK_MAX. A coin arriving in the same cycle is rejected if the old stock was 0.
- VEND (one cycle):
  - stock <= stock-1.
  - credit <= credit-PRICE.
  - Next state: CHANGE if credit-PRICE > 0, else IDLE.
- CHANGE / REFUND:
  - Each cycle: return5=1, credit <= credit-5.
  - Leave for IDLE on the edge where credit reaches 0.
  - Number of pulses = credit/5 on entry.
- Reject conditions:
  - coin==11 in any state.
  - A valid coin while state != IDLE.
  - A valid coin while stock==0.
  - In all cases credit is unchanged.
- Other inputs outside IDLE: cancel and refill are ignored in non-IDLE states.
- sold_out = (stock==0), combinational from the stock register.
- Credit arithmetic:
  - Unsigned, width CREDIT_W.
  - Maximum pre-vend credit is PRICE-5+10, which fits by the PRICE constraint; no wrap is possible.
  - Stock never decrements below 0, because VEND is unreachable with stock==0.

Decomposition:
- Shared package vending_pkg holds:
  - the state encoding constants (IDLE/VEND/CHANGE/REFUND);
  - the coin codes COIN_NONE/COIN_5/COIN_10/COIN_INV;
  - the coin values 5 and 10.
- One natural sub-module, vm_coin_decode: a combinational coin code to {valid, value} decoder, reused by the next-gen acceptor.
- Everything else, FSM and counters, lives in vending_machine_param.

Test Plan (PRICE=15, STOCK_MAX=2 unless noted):
- 5,5,5 in separate cycles -> credit 5,10,15; dispense one cycle after the third coin; zero return5 pulses; credit=0; stock=1.
- 10,10 -> dispense one cycle after the second coin, then exactly 1 return5 pulse; final credit=0, state IDLE.
- PRICE=25: 10,10,10 -> dispense, 1 return5. Then 5 followed by cancel -> REFUND, 1 return5, credit=0, no dispense.
- coin=11 in IDLE, and coin=01 during CHANGE -> reject pulse on the next cycle each time; credit unchanged.
- Two sales -> stock=0, sold_out=1; coin 10 rejected; refill -> stock=2, sold_out=0; the next 5,10 vends.
- 5 inserted, then reset asserted asynchronously mid-cycle -> state=000, credit=0, stock=STOCK_MAX, no return5.
